// File: rtl/cpu7_excp_pkg.sv
// Shared constants for the cpu7 machine-mode trap unit: CSR addresses,
// cause codes, mtvec modes and the redirect FSM encoding.
package cpu7_excp_pkg;

    localparam int CODE_W = 5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [CODE_W-1:0] IRQ_MSI_CODE = 5'd3;
    localparam logic [CODE_W-1:0] IRQ_MTI_CODE = 5'd7;
    localparam logic [CODE_W-1:0] IRQ_MEI_CODE = 5'd11;

    localparam logic [CODE_W-1:0] EXC_IADDR_MISALIGN = 5'd0;
    localparam logic [CODE_W-1:0] EXC_IACCESS_FAULT  = 5'd1;
    localparam logic [CODE_W-1:0] EXC_ILLEGAL_INSTR  = 5'd2;
    localparam logic [CODE_W-1:0] EXC_BREAKPOINT     = 5'd3;
    localparam logic [CODE_W-1:0] EXC_LADDR_MISALIGN = 5'd4;
    localparam logic [CODE_W-1:0] EXC_LACCESS_FAULT  = 5'd5;
    localparam logic [CODE_W-1:0] EXC_ECALL_M        = 5'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/cpu7_excp_arb.sv
// Combinational event arbiter: lowest exception cause first, then
// MEI > MSI > MTI, then mret.
module cpu7_excp_arb
    import cpu7_excp_pkg::*;
#(
    parameter int NEXCP = 16
) (
    input  logic [NEXCP-1:0]  excp_cause_vec,
    input  logic [2:0]        irq_pend,
    input  logic              mret,
    output logic              take,
    output logic              is_irq,
    output logic [CODE_W-1:0] code,
    output logic              is_mret
);

    // Priority selection; irq_pend is ordered {MEI, MTI, MSI}
    always_comb begin
        take    = 1'b0;
        is_irq  = 1'b0;
        code    = '0;
        is_mret = 1'b0;
        if (|excp_cause_vec) begin
            take = 1'b1;
            for (int i = NEXCP - 1; i >= 0; i--) begin
                code = excp_cause_vec[i] ? CODE_W'(i) : code;
            end
        end else if (irq_pend[2]) begin
            take   = 1'b1;
            is_irq = 1'b1;
            code   = IRQ_MEI_CODE;
        end else if (irq_pend[0]) begin
            take   = 1'b1;
            is_irq = 1'b1;
            code   = IRQ_MSI_CODE;
        end else if (irq_pend[1]) begin
            take   = 1'b1;
            is_irq = 1'b1;
            code   = IRQ_MTI_CODE;
        end else if (mret) begin
            take    = 1'b1;
            is_mret = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/cpu7_excp.sv
// cpu7 machine-mode trap unit: takes commit-stage exceptions, interrupts and
// mret, owns the trap CSRs and holds a fetch redirect until acknowledged.
module cpu7_excp
    import cpu7_excp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NEXCP       = 16,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             excp_valid,
    input  logic [XLEN-1:0]  excp_pc,
    input  logic [NEXCP-1:0] excp_cause_vec,
    input  logic [XLEN-1:0]  excp_tval,
    input  logic             excp_mret,
    input  logic             irq_msip,
    input  logic             irq_mtip,
    input  logic             irq_meip,
    input  logic             csr_wr_ena,
    input  logic [11:0]      csr_wr_addr,
    input  logic [XLEN-1:0]  csr_wr_data,
    input  logic [XLEN-1:0]  csr_mtvec,
    output logic [XLEN-1:0]  csr_mepc,
    output logic [XLEN-1:0]  csr_mcause,
    output logic [XLEN-1:0]  csr_mtval,
    output logic             csr_mstatus_mie,
    output logic             csr_mstatus_mpie,
    output logic [XLEN-1:0]  csr_mie,
    output logic [XLEN-1:0]  csr_mip,
    output logic             excp_flush_pc_ena,
    output logic [XLEN-1:0]  excp_flush_pc,
    input  logic             excp_flush_ack,
    output logic             excp_busy
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0]   mepc_r, mcause_r, mtval_r, flush_pc_r;
    logic              mstatus_mie_r, mstatus_mpie_r, flush_ena_r, busy_r;
    logic [2:0]        mie_r, mip_r;
    state_t            state_r;

    logic [2:0]        irq_pend_s;
    logic              arb_take_s, arb_irq_s, arb_mret_s;
    logic [CODE_W-1:0] arb_code_s;
    logic              event_s, trap_s, mret_s;
    logic [XLEN-1:0]   base_s, target_s, mcause_next_s;

    assign irq_pend_s = mip_r & mie_r & {3{mstatus_mie_r}};

    cpu7_excp_arb #(.NEXCP(NEXCP)) u_arb (
        .excp_cause_vec (excp_cause_vec),
        .irq_pend       (irq_pend_s),
        .mret           (excp_mret),
        .take           (arb_take_s),
        .is_irq         (arb_irq_s),
        .code           (arb_code_s),
        .is_mret        (arb_mret_s)
    );

    // Event qualification, trap cause word and redirect target
    always_comb begin
        event_s                   = (state_r == ST_IDLE) && excp_valid && arb_take_s;
        trap_s                    = event_s && !arb_mret_s;
        mret_s                    = event_s && arb_mret_s;
        mcause_next_s             = '0;
        mcause_next_s[XLEN-1]     = arb_irq_s;
        mcause_next_s[CODE_W-1:0] = arb_code_s;
        base_s                    = csr_mtvec & ALIGN_MASK;
        if (arb_mret_s) begin
            target_s = mepc_r;
        end else if (VECTORED_EN && arb_irq_s && (csr_mtvec[1:0] == MTVEC_VECTORED)) begin
            target_s = base_s + XLEN'({arb_code_s, 2'b00});
        end else begin
            target_s = base_s;
        end
    end

    // Trap CSRs; trap/mret updates are placed last so they override a same-cycle write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mepc_r         <= '0;
            mcause_r       <= '0;
            mtval_r        <= '0;
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_r          <= 3'b000;
            mip_r          <= 3'b000;
        end else begin
            mip_r <= {irq_meip, irq_mtip, irq_msip};
            if (csr_wr_ena) begin
                case (csr_wr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_r  <= csr_wr_data[3];
                        mstatus_mpie_r <= csr_wr_data[7];
                    end
                    CSR_MIE:    mie_r    <= {csr_wr_data[11], csr_wr_data[7], csr_wr_data[3]};
                    CSR_MEPC:   mepc_r   <= csr_wr_data & ALIGN_MASK;
                    CSR_MCAUSE: mcause_r <= csr_wr_data;
                    CSR_MTVAL:  mtval_r  <= csr_wr_data;
                    default: begin
                    end
                endcase
            end
            if (trap_s) begin
                mepc_r         <= excp_pc & ALIGN_MASK;
                mcause_r       <= mcause_next_s;
                mtval_r        <= arb_irq_s ? '0 : excp_tval;
                mstatus_mpie_r <= mstatus_mie_r;
                mstatus_mie_r  <= 1'b0;
            end else if (mret_s) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b1;
            end
        end
    end

    // Redirect FSM: request is held until the fetch unit acknowledges it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            flush_ena_r <= 1'b0;
            flush_pc_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (event_s) begin
                        state_r     <= ST_REDIRECT;
                        flush_ena_r <= 1'b1;
                        flush_pc_r  <= target_s;
                        busy_r      <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (excp_flush_ack) begin
                        state_r     <= ST_IDLE;
                        flush_ena_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    flush_ena_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Expand the three implemented interrupt bits onto their CSR positions
    always_comb begin
        csr_mie     = '0;
        csr_mip     = '0;
        csr_mie[11] = mie_r[2];
        csr_mie[7]  = mie_r[1];
        csr_mie[3]  = mie_r[0];
        csr_mip[11] = mip_r[2];
        csr_mip[7]  = mip_r[1];
        csr_mip[3]  = mip_r[0];
    end

    assign csr_mepc          = mepc_r;
    assign csr_mcause        = mcause_r;
    assign csr_mtval         = mtval_r;
    assign csr_mstatus_mie   = mstatus_mie_r;
    assign csr_mstatus_mpie  = mstatus_mpie_r;
    assign excp_flush_pc_ena = flush_ena_r;
    assign excp_flush_pc     = flush_pc_r;
    assign excp_busy         = busy_r;

endmodule

// File: tb/tb_cpu7_excp.sv
// Self-checking bench for cpu7_excp: vector table plus hand-written corner
// sequences; redirect expectations flow through a scoreboard queue.
module tb_cpu7_excp;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_valid;
    logic [31:0] excp_pc;
    logic [15:0] excp_cause_vec;
    logic [31:0] excp_tval;
    logic        excp_mret;
    logic        irq_msip, irq_mtip, irq_meip;
    logic        csr_wr_ena;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc, csr_mcause, csr_mtval, csr_mie, csr_mip;
    logic        csr_mstatus_mie, csr_mstatus_mpie;
    logic        excp_flush_pc_ena;
    logic [31:0] excp_flush_pc;
    logic        excp_flush_ack;
    logic        excp_busy;

    cpu7_excp dut (
        .clk               (clk),
        .reset             (reset),
        .excp_valid        (excp_valid),
        .excp_pc           (excp_pc),
        .excp_cause_vec    (excp_cause_vec),
        .excp_tval         (excp_tval),
        .excp_mret         (excp_mret),
        .irq_msip          (irq_msip),
        .irq_mtip          (irq_mtip),
        .irq_meip          (irq_meip),
        .csr_wr_ena        (csr_wr_ena),
        .csr_wr_addr       (csr_wr_addr),
        .csr_wr_data       (csr_wr_data),
        .csr_mtvec         (csr_mtvec),
        .csr_mepc          (csr_mepc),
        .csr_mcause        (csr_mcause),
        .csr_mtval         (csr_mtval),
        .csr_mstatus_mie   (csr_mstatus_mie),
        .csr_mstatus_mpie  (csr_mstatus_mpie),
        .csr_mie           (csr_mie),
        .csr_mip           (csr_mip),
        .excp_flush_pc_ena (excp_flush_pc_ena),
        .excp_flush_pc     (excp_flush_pc),
        .excp_flush_ack    (excp_flush_ack),
        .excp_busy         (excp_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic        mie;
        logic        mpie;
        int          len;
    } exp_t;

    typedef struct {
        logic [2:0]  irq;      // {meip, mtip, msip}
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mepc;
        logic [31:0] mtvec;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        mret;
        logic        redir;
        int          ack;
        logic [31:0] e_pc;
        logic [31:0] e_mcause;
        logic [31:0] e_mepc;
        logic [31:0] e_mtval;
        logic        e_mie;
        logic        e_mpie;
    } vec_t;

    localparam int NV = 8;
    vec_t tv[NV];
    exp_t sb_q[$];
    exp_t cur;
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hi_cnt  = 0;
    logic prev_ena = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] irq_to_csr(input logic [2:0] irq);
        logic [31:0] v;
        v     = 32'h0;
        v[11] = irq[2];
        v[7]  = irq[1];
        v[3]  = irq[0];
        return v;
    endfunction

    // Redirect monitor: pops an expectation on each rising flush request
    always @(negedge clk) begin
        if (excp_flush_pc_ena && !prev_ena) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_redirect", 32'(excp_flush_pc_ena), 32'h0);
            end else begin
                cur = sb_q.pop_front();
                chk("flush_pc", excp_flush_pc, cur.pc);
                chk("mcause", csr_mcause, cur.mcause);
                chk("mepc", csr_mepc, cur.mepc);
                chk("mtval", csr_mtval, cur.mtval);
                chk("mstatus_mie", 32'(csr_mstatus_mie), 32'(cur.mie));
                chk("mstatus_mpie", 32'(csr_mstatus_mpie), 32'(cur.mpie));
                chk("busy", 32'(excp_busy), 32'h1);
            end
            hi_cnt = 1;
        end else if (excp_flush_pc_ena && prev_ena) begin
            hi_cnt++;
            chk("flush_pc_hold", excp_flush_pc, cur.pc);
        end else if (!excp_flush_pc_ena && prev_ena) begin
            chk("ena_len", 32'(hi_cnt), 32'(cur.len));
        end
        prev_ena = excp_flush_pc_ena;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_wr_ena  = 1'b1;
        csr_wr_addr = addr;
        csr_wr_data = data;
        step();
        csr_wr_ena  = 1'b0;
    endtask

    task automatic setup(input logic [2:0] irq, input logic [31:0] mst, input logic [31:0] mie,
                         input logic [31:0] mepc, input logic [31:0] mtvec);
        {irq_meip, irq_mtip, irq_msip} = irq;
        csr_mtvec = mtvec;
        csr_write(12'h300, mst);
        csr_write(12'h304, mie);
        csr_write(12'h341, mepc);
        step();
    endtask

    task automatic issue(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                         input logic mret, input logic redir, input exp_t ex, input int ack_dly);
        excp_valid     = 1'b1;
        excp_cause_vec = cause[15:0];
        excp_pc        = pc;
        excp_tval      = tval;
        excp_mret      = mret;
        if (redir) sb_q.push_back(ex);
        step();
        excp_valid     = 1'b0;
        excp_cause_vec = 16'h0;
        excp_mret      = 1'b0;
        if (redir) begin
            repeat (ack_dly) step();
            excp_flush_ack = 1'b1;
            step();
            excp_flush_ack = 1'b0;
        end
        step();
    endtask

    initial begin
        tv[0] = '{3'b000, 32'h8, 32'h0,   32'h0,   32'h8000_0000, 32'h4,   32'h100, 32'hFFFF_FFFF, 1'b0, 1'b1, 3,
                  32'h8000_0000, 32'h2, 32'h100, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tv[1] = '{3'b010, 32'h8, 32'h80,  32'h0,   32'h1001, 32'h0,   32'h40,  32'h1234, 1'b0, 1'b1, 0,
                  32'h101C, 32'h8000_0007, 32'h40, 32'h0, 1'b0, 1'b1};
        tv[2] = '{3'b000, 32'h0, 32'h0,   32'h0,   32'h200,  32'h804, 32'h300, 32'h55,   1'b0, 1'b1, 1,
                  32'h200, 32'h2, 32'h300, 32'h55, 1'b0, 1'b0};
        tv[3] = '{3'b110, 32'h8, 32'h880, 32'h0,   32'h1001, 32'h0,   32'h44,  32'h99,   1'b0, 1'b1, 0,
                  32'h102C, 32'h8000_000B, 32'h44, 32'h0, 1'b0, 1'b1};
        tv[4] = '{3'b101, 32'h8, 32'h808, 32'h0,   32'h1001, 32'h20,  32'h503, 32'hABCD, 1'b0, 1'b1, 2,
                  32'h1000, 32'h5, 32'h500, 32'hABCD, 1'b0, 1'b1};
        tv[5] = '{3'b000, 32'h80, 32'h0,  32'h203, 32'h1001, 32'h0,   32'h10,  32'h77,   1'b1, 1'b1, 0,
                  32'h200, 32'h5, 32'h200, 32'hABCD, 1'b1, 1'b1};
        tv[6] = '{3'b010, 32'h0, 32'h80,  32'h104, 32'h1001, 32'h0,   32'h20,  32'h0,    1'b0, 1'b0, 0,
                  32'h0, 32'h5, 32'h104, 32'hABCD, 1'b0, 1'b0};
        tv[7] = '{3'b001, 32'h8, 32'h8,   32'h0,   32'h2000, 32'h0,   32'h80,  32'h5,    1'b0, 1'b1, 1,
                  32'h2000, 32'h8000_0003, 32'h80, 32'h0, 1'b0, 1'b1};

        reset = 1'b0;
        excp_valid = 1'b0; excp_pc = 32'h0; excp_cause_vec = 16'h0; excp_tval = 32'h0;
        excp_mret = 1'b0; irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
        csr_wr_ena = 1'b0; csr_wr_addr = 12'h0; csr_wr_data = 32'h0; csr_mtvec = 32'h0;
        excp_flush_ack = 1'b0;
        #3;
        chk("rst_mepc", csr_mepc, 32'h0);
        chk("rst_mcause", csr_mcause, 32'h0);
        chk("rst_mtval", csr_mtval, 32'h0);
        chk("rst_mie", csr_mie, 32'h0);
        chk("rst_mip", csr_mip, 32'h0);
        chk("rst_mstatus", {30'h0, csr_mstatus_mpie, csr_mstatus_mie}, 32'h0);
        chk("rst_ena", 32'(excp_flush_pc_ena), 32'h0);
        chk("rst_flush_pc", excp_flush_pc, 32'h0);
        chk("rst_busy", 32'(excp_busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            setup(tv[i].irq, tv[i].mstatus, tv[i].mie, tv[i].mepc, tv[i].mtvec);
            chk($sformatf("v%0d_mip", i), csr_mip, irq_to_csr(tv[i].irq));
            chk($sformatf("v%0d_mie", i), csr_mie, tv[i].mie);
            e = '{tv[i].e_pc, tv[i].e_mcause, tv[i].e_mepc, tv[i].e_mtval, tv[i].e_mie, tv[i].e_mpie, tv[i].ack + 1};
            issue(tv[i].cause, tv[i].pc, tv[i].tval, tv[i].mret, tv[i].redir, e, tv[i].ack);
            if (!tv[i].redir) begin
                chk($sformatf("v%0d_no_redirect", i), 32'(excp_flush_pc_ena), 32'h0);
                chk($sformatf("v%0d_mcause", i), csr_mcause, tv[i].e_mcause);
                chk($sformatf("v%0d_mepc", i), csr_mepc, tv[i].e_mepc);
                chk($sformatf("v%0d_mtval", i), csr_mtval, tv[i].e_mtval);
                chk($sformatf("v%0d_mie_bit", i), 32'(csr_mstatus_mie), 32'(tv[i].e_mie));
            end
        end

        // second exception while redirecting, plus a same-cycle mcause write
        setup(3'b000, 32'h0, 32'h0, 32'h0, 32'h3000);
        excp_valid = 1'b1; excp_cause_vec = 16'h8; excp_pc = 32'h600; excp_tval = 32'h11;
        csr_wr_ena = 1'b1; csr_wr_addr = 12'h342; csr_wr_data = 32'h77;
        sb_q.push_back('{32'h3000, 32'h3, 32'h600, 32'h11, 1'b0, 1'b0, 3});
        step();
        csr_wr_ena = 1'b0;
        excp_cause_vec = 16'h4; excp_pc = 32'h700; excp_tval = 32'h22;
        step();
        step();
        excp_valid = 1'b0; excp_cause_vec = 16'h0;
        excp_flush_ack = 1'b1;
        step();
        excp_flush_ack = 1'b0;
        step();
        chk("busy_mcause", csr_mcause, 32'h3);
        chk("busy_mepc", csr_mepc, 32'h600);
        chk("busy_mtval", csr_mtval, 32'h11);

        // MIE written in the same cycle as excp_valid does not yet enable the interrupt
        setup(3'b010, 32'h0, 32'h80, 32'h0, 32'h2000);
        excp_valid = 1'b1; excp_pc = 32'h90;
        csr_wr_ena = 1'b1; csr_wr_addr = 12'h300; csr_wr_data = 32'h8;
        step();
        excp_valid = 1'b0; csr_wr_ena = 1'b0;
        step();
        chk("mie_gate_no_redirect", 32'(excp_flush_pc_ena), 32'h0);
        issue(32'h0, 32'h94, 32'h0, 1'b0, 1'b1, '{32'h2000, 32'h8000_0007, 32'h94, 32'h0, 1'b0, 1'b1, 1}, 0);

        // asynchronous reset in the middle of a redirect
        excp_valid = 1'b1; excp_cause_vec = 16'h1; excp_pc = 32'h800; excp_tval = 32'h3;
        sb_q.push_back('{32'h2000, 32'h0, 32'h800, 32'h3, 1'b0, 1'b0, 1});
        step();
        excp_valid = 1'b0; excp_cause_vec = 16'h0;
        #5;
        reset = 1'b0;
        #1;
        chk("arst_ena", 32'(excp_flush_pc_ena), 32'h0);
        chk("arst_busy", 32'(excp_busy), 32'h0);
        chk("arst_flush_pc", excp_flush_pc, 32'h0);
        chk("arst_mepc", csr_mepc, 32'h0);
        chk("arst_mcause", csr_mcause, 32'h0);
        chk("arst_mtval", csr_mtval, 32'h0);
        chk("arst_mip", csr_mip, 32'h0);
        chk("arst_mstatus", {30'h0, csr_mstatus_mpie, csr_mstatus_mie}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        issue(32'h4, 32'h900, 32'h1, 1'b0, 1'b1, '{32'h2000, 32'h2, 32'h900, 32'h1, 1'b0, 1'b0, 1}, 0);

        step();
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        chk("final_ena", 32'(excp_flush_pc_ena), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu7_excp.md
Name: cpu7_excp

Overview:
Machine-mode trap unit for the cpu7 core, the successor to the cpu6 single-cause exception block. It arbitrates a parametrised vector of synchronous exception causes plus three machine interrupts at the commit stage. It owns mepc/mcause/mtval/mstatus.MIE/MPIE/mie, supports direct and vectored mtvec, executes mret, and holds a redirect request to the fetch unit until acknowledged.

Parameters:
XLEN, 32, datapath/CSR width
NEXCP, 16, exception cause bits; bit i = mcause code i
VECTORED_EN, 1, 1 honours mtvec.MODE=1 for interrupts; 0 always uses direct mode

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
excp_valid  in  1  commit-stage instruction valid (instruction boundary)
excp_pc  in  XLEN  PC of the commit-stage instruction
excp_cause_vec  in  NEXCP  raised exception causes for the commit instruction
excp_tval  in  XLEN  faulting address or instruction bits
excp_mret  in  1  commit instruction is mret
irq_msip, irq_mtip, irq_meip  in  1 each  level interrupt requests
csr_wr_ena  in  1  CSR write strobe
csr_wr_addr  in  12  CSR address
csr_wr_data  in  XLEN  write data
csr_mtvec  in  XLEN  trap vector (BASE[XLEN-1:2], MODE[1:0])
csr_mepc, csr_mcause, csr_mtval  out  XLEN  CSR read values
csr_mstatus_mie, csr_mstatus_mpie  out  1  mstatus bits
csr_mie  out  XLEN  mie (only bits 3, 7, 11 implemented; others read 0)
csr_mip  out  XLEN  registered pending (bits 3, 7, 11)
excp_flush_pc_ena  out  1  redirect/flush request
excp_flush_pc  out  XLEN  redirect target
excp_flush_ack  in  1  fetch unit accepted the redirect
excp_busy  out  1  FSM in REDIRECT

Behaviour:
- Reset (async, reset=0): all CSRs, mip, excp_flush_pc_ena, excp_flush_pc and excp_busy are 0; FSM is IDLE.
- mip is registered from the irq_* inputs every cycle, giving 1 cycle of latency. Software writes to mip are ignored.
- Pending interrupt = mip & mie & {MIE}. Priority: MEI(11) > MSI(3) > MTI(7).
- Exception select: lowest set bit of excp_cause_vec wins.
- Event evaluation happens only in IDLE with excp_valid=1. Priority: exception > interrupt > mret.
- Trap entry (exception or interrupt), registered at the next edge:
  - mepc <= {excp_pc[XLEN-1:2], 2'b0}
  - mcause <= {isIrq, code}
  - mtval <= excp_tval for exceptions, 0 for interrupts
  - MPIE <= MIE; MIE <= 0
  - flush target:
    - csr_mtvec.BASE<<2 for exceptions, and for interrupts when MODE!=1 or VECTORED_EN=0.
    - (BASE<<2) + 4*code for interrupts when MODE==1 and VECTORED_EN=1.
- mret: target = mepc; MIE <= MPIE; MPIE <= 1; mepc, mcause and mtval unchanged.
- FSM:
  - IDLE→REDIRECT on any event. excp_flush_pc_ena=1 and excp_flush_pc are registered, so they are valid from cycle N+1 after a cycle-N event.
  - REDIRECT holds both outputs stable until excp_flush_ack=1 is sampled, then goes to IDLE with ena=0 the next cycle.
  - If ack is already high in the first REDIRECT cycle, ena lasts exactly 1 cycle.
  - All excp_valid events, and interrupts, are ignored in REDIRECT (the pipeline is being flushed).
- CSR writes (0x300 mstatus bits 3/7, 0x304 mie, 0x341 mepc with bits[1:0] forced 0, 0x342 mcause, 0x343 mtval) take effect next edge in any state. A trap/mret update in the same cycle wins for the fields it touches.
- A new MIE value from a CSR write gates interrupts from the following cycle.
- Asserting reset in REDIRECT drops excp_flush_pc_ena immediately, without waiting for the clock.

Decomposition:
- Package cpu7_excp_pkg holds:
  - CSR address constants
  - interrupt cause codes (3, 7, 11) and exception code constants
  - FSM state encoding (IDLE, REDIRECT)
  - mtvec MODE encodings
- Sub-module cpu7_excp_arb: combinational priority encoder taking excp_cause_vec, pending interrupts and mret. It outputs take, isIrq, code and isMret.

Test Plan:
- Illegal instruction: mtvec=0x8000_0000, cause bit 2, pc=0x100, tval=0xFFFF_FFFF, ack delayed 3 cycles.
  - Required: ena high from N+1 for 4 cycles, flush_pc=0x8000_0000, mepc=0x100, mcause=2, mtval=0xFFFF_FFFF, MIE=0.
- Vectored timer interrupt: mtvec=0x1001, MIE=1, mie=0x80, irq_mtip=1, then excp_valid at pc=0x40.
  - Required: flush_pc=0x101C, mcause=0x8000_0007, mepc=0x40, mtval=0, MPIE=1, MIE=0.
- Priority:
  - cause bits 2 and 11 in the same cycle → mcause=2.
  - meip+mtip with mie=0x880 → mcause=0x8000_000B.
  - exception plus pending interrupt → exception taken.
- mret: mepc=0x200, MPIE=1, MIE=0, excp_mret=1 → flush_pc=0x200, MIE=1, MPIE=1.
- Masking/busy:
  - MIE=0 with mtip pending → no redirect.
  - A second excp_valid exception during REDIRECT → mcause unchanged.
- Async reset asserted mid-REDIRECT → ena=0 before the next edge, all CSRs 0, FSM IDLE.
